// File: rtl/lipsi_ctrl_if.sv
// Bus bundle between the Lipsi sequencer and its instruction ROM, register memory and ALU.
// The master side is the sequencer; the slave side is the surrounding memories and ALU.
interface lipsi_ctrl_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [3:0] dmem_addr;
    logic       dmem_we;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic [3:0] alu_ctrl;
    logic [7:0] rd_data;
    logic [7:0] acc_out;
    logic [7:0] acc_in;
    logic [7:0] pc;
    logic       halted;

    modport master (
        output imem_addr, dmem_addr, dmem_we, dmem_wdata,
        output alu_ctrl, rd_data, acc_out, pc, halted,
        input  imem_rdata, dmem_rdata, acc_in
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_we, dmem_wdata,
        input  alu_ctrl, rd_data, acc_out, pc, halted,
        output imem_rdata, dmem_rdata, acc_in
    );
endinterface

// File: rtl/lipsi_ctrl.sv
// Lipsi fetch/decode/execute sequencer: owns PC, IR and accumulator, and steers the ALU,
// the synchronous instruction ROM and the 16-entry register memory.
module lipsi_ctrl #(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter logic [3:0] IDLE_ALU_CTRL = 4'b1111
) (
    input  logic         clk,
    input  logic         rst_n,
    lipsi_ctrl_if.master ctrl_bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_MEM,
        S_OPERAND,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU_REG,
        OP_SHIFT,
        OP_ST,
        OP_IMM,
        OP_BRANCH,
        OP_HALT
    } opclass_t;

    function automatic opclass_t classify(input logic [7:0] op);
        opclass_t c;
        if (op[7]) begin
            c = OP_ALU_REG;
        end else if (op[6]) begin
            c = OP_SHIFT;
        end else begin
            case (op[5:4])
                2'b00:   c = OP_ST;
                2'b01:   c = OP_IMM;
                2'b10:   c = OP_BRANCH;
                default: c = OP_HALT;
            endcase
        end
        return c;
    endfunction

    // Condition is evaluated on the accumulator as left by the previous instruction.
    function automatic logic branch_taken(input logic [1:0] cc, input logic [7:0] acc);
        logic t;
        case (cc)
            2'b00:   t = 1'b1;
            2'b01:   t = (acc == 8'h00);
            2'b10:   t = (acc != 8'h00);
            default: t = acc[7];
        endcase
        return t;
    endfunction

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_acc;
    logic [7:0] r_ir;

    state_t     w_state_next;
    logic [7:0] w_pc_next;
    logic [7:0] w_acc_next;
    logic [7:0] w_ir_next;
    logic [3:0] w_alu_ctrl;
    logic [7:0] w_rd_data;
    logic [3:0] w_dmem_addr;
    logic       w_dmem_we;
    opclass_t   w_dec_class;
    opclass_t   w_ir_class;

    assign w_dec_class = classify(ctrl_bus.imem_rdata);
    assign w_ir_class  = classify(r_ir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_acc   <= 8'h00;
            r_ir    <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_acc   <= w_acc_next;
            r_ir    <= w_ir_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_acc_next   = r_acc;
        w_ir_next    = r_ir;
        w_alu_ctrl   = IDLE_ALU_CTRL;
        w_rd_data    = 8'h00;
        w_dmem_addr  = r_ir[3:0];
        w_dmem_we    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_pc_next    = r_pc + 8'd1;
                w_state_next = S_DECODE;
            end

            S_DECODE: begin
                w_ir_next   = ctrl_bus.imem_rdata;
                w_dmem_addr = ctrl_bus.imem_rdata[3:0];
                case (w_dec_class)
                    OP_ALU_REG: w_state_next = S_EXEC_MEM;
                    OP_SHIFT: begin
                        w_alu_ctrl   = ctrl_bus.imem_rdata[7:4];
                        w_acc_next   = ctrl_bus.acc_in;
                        w_state_next = S_FETCH;
                    end
                    OP_ST: begin
                        w_dmem_we    = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    OP_IMM, OP_BRANCH: begin
                        // The operand byte is addressed this cycle; pc then points past it.
                        w_pc_next    = r_pc + 8'd1;
                        w_state_next = S_OPERAND;
                    end
                    default: w_state_next = S_HALT;
                endcase
            end

            S_EXEC_MEM: begin
                w_rd_data    = ctrl_bus.dmem_rdata;
                w_alu_ctrl   = r_ir[7:4];
                w_acc_next   = ctrl_bus.acc_in;
                w_state_next = S_FETCH;
            end

            S_OPERAND: begin
                if (w_ir_class == OP_IMM) begin
                    w_rd_data  = ctrl_bus.imem_rdata;
                    w_alu_ctrl = {1'b1, r_ir[2:0]};
                    w_acc_next = ctrl_bus.acc_in;
                end else if (branch_taken(r_ir[1:0], r_acc)) begin
                    w_pc_next = ctrl_bus.imem_rdata;
                end
                w_state_next = S_FETCH;
            end

            S_HALT: w_state_next = S_HALT;

            default: w_state_next = S_FETCH;
        endcase
    end

    assign ctrl_bus.imem_addr  = r_pc;
    assign ctrl_bus.pc         = r_pc;
    assign ctrl_bus.dmem_addr  = w_dmem_addr;
    assign ctrl_bus.dmem_we    = w_dmem_we;
    assign ctrl_bus.dmem_wdata = r_acc;
    assign ctrl_bus.alu_ctrl   = w_alu_ctrl;
    assign ctrl_bus.rd_data    = w_rd_data;
    assign ctrl_bus.acc_out    = r_acc;
    assign ctrl_bus.halted     = (r_state == S_HALT);

`ifndef SYNTHESIS
    a_single_write: assert property (@(posedge clk) disable iff (!rst_n)
        ctrl_bus.dmem_we |=> !ctrl_bus.dmem_we);
    a_halt_frozen: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_HALT) |=> ($stable(r_pc) && $stable(r_acc) && (r_state == S_HALT)));
`endif

endmodule

// File: tb/tb_lipsi_ctrl.sv
// Directed bench for lipsi_ctrl: ROM, register memory and ALU models around the sequencer,
// a table of short programs plus hand-written cycle-level sequences.
module tb_lipsi_ctrl;

    typedef struct {
        string       name;
        logic [63:0] prog;      // first program byte in the top byte
        logic [7:0]  hi;        // content of ROM address 0xFF
        int          cycles;
        logic [7:0]  exp_pc;
        logic [7:0]  exp_acc;
        logic        exp_halt;
        int          exp_wr;
    } vec_t;

    logic clk;
    logic rst_n;
    lipsi_ctrl_if bus ();

    lipsi_ctrl #(.RESET_PC(8'h00), .IDLE_ALU_CTRL(4'b1111)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl_bus (bus.master)
    );

    logic [7:0] rom  [256];
    logic [7:0] dmem [16];
    int         wr_cnt;
    int         checks;
    int         errors;
    vec_t       vecs [14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            4'h8, 4'hA: r = a + b;
            4'h9, 4'hB: r = a - b;
            4'hC:       r = a & b;
            4'hD:       r = a | b;
            4'hE:       r = a ^ b;
            4'h4:       r = {a[6:0], 1'b0};
            4'h5:       r = {1'b0, a[7:1]};
            4'h6:       r = {a[6:0], a[7]};
            4'h7:       r = {a[0], a[7:1]};
            default:    r = b;
        endcase
        return r;
    endfunction

    assign bus.acc_in = alu(bus.alu_ctrl, bus.acc_out, bus.rd_data);

    always @(posedge clk) begin
        bus.imem_rdata <= rom[bus.imem_addr];
        bus.dmem_rdata <= dmem[bus.dmem_addr];
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) dmem[k] <= 8'h00;
            wr_cnt <= 0;
        end else if (bus.dmem_we) begin
            dmem[bus.dmem_addr] <= bus.dmem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at a falling edge with rst_n just released and the program loaded.
    task automatic load_and_reset(input logic [63:0] prog, input logic [7:0] hi);
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 256; k++) rom[k] = 8'h30;
        rom[255] = hi;
        for (int k = 0; k < 8; k++) rom[k] = prog[63-8*k -: 8];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        load_and_reset(vecs[idx].prog, vecs[idx].hi);
        repeat (vecs[idx].cycles) @(negedge clk);
        chk({vecs[idx].name, ".pc"},     {24'd0, bus.pc},      {24'd0, vecs[idx].exp_pc});
        chk({vecs[idx].name, ".acc"},    {24'd0, bus.acc_out}, {24'd0, vecs[idx].exp_acc});
        chk({vecs[idx].name, ".halted"}, {31'd0, bus.halted},  {31'd0, vecs[idx].exp_halt});
        chk({vecs[idx].name, ".writes"}, wr_cnt,               vecs[idx].exp_wr);
        $display("vec %0d %s: pc=%02h acc=%02h halted=%0b writes=%0d",
                 idx, vecs[idx].name, bus.pc, bus.acc_out, bus.halted, wr_cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        for (int k = 0; k < 256; k++) rom[k] = 8'h30;

        vecs[0]  = '{"imm_ld_add",   64'h1705_1003_3030_3030, 8'h30,  6, 8'h04, 8'h08, 1'b0, 0};
        vecs[1]  = '{"imm_halt",     64'h1705_1003_3030_3030, 8'h30, 12, 8'h05, 8'h08, 1'b1, 0};
        vecs[2]  = '{"st_sub",       64'h1708_0292_3030_3030, 8'h30,  8, 8'h04, 8'h00, 1'b0, 1};
        vecs[3]  = '{"br_z_taken",   64'h2110_3030_3030_3030, 8'h30,  3, 8'h10, 8'h00, 1'b0, 0};
        vecs[4]  = '{"br_z_not",     64'h1701_2110_3030_3030, 8'h30,  6, 8'h04, 8'h01, 1'b0, 0};
        vecs[5]  = '{"br_neg_taken", 64'h1780_2320_3030_3030, 8'h30,  6, 8'h20, 8'h80, 1'b0, 0};
        vecs[6]  = '{"br_neg_not",   64'h177F_2320_3030_3030, 8'h30,  6, 8'h04, 8'h7F, 1'b0, 0};
        vecs[7]  = '{"br_nz_taken",  64'h1701_2240_3030_3030, 8'h30,  6, 8'h40, 8'h01, 1'b0, 0};
        vecs[8]  = '{"br_always",    64'h1755_2033_3030_3030, 8'h30,  6, 8'h33, 8'h55, 1'b0, 0};
        vecs[9]  = '{"shift_right",  64'h1780_5030_3030_3030, 8'h30,  5, 8'h03, 8'h40, 1'b0, 0};
        vecs[10] = '{"shift_left",   64'h1781_4030_3030_3030, 8'h30,  5, 8'h03, 8'h02, 1'b0, 0};
        vecs[11] = '{"pc_wrap",      64'h20FF_3030_3030_3030, 8'h17,  6, 8'h01, 8'h20, 1'b0, 0};
        vecs[12] = '{"and_reg",      64'h170C_0317_0AC3_3030, 8'h30, 11, 8'h06, 8'h08, 1'b0, 1};
        vecs[13] = '{"xor_imm",      64'h17F0_16FF_3030_3030, 8'h30,  6, 8'h04, 8'h0F, 1'b0, 0};

        // Reset applied before any clock edge has happened.
        #1 rst_n = 1'b0;
        #1;
        chk("por.pc",       {24'd0, bus.pc},       32'h00);
        chk("por.acc",      {24'd0, bus.acc_out},  32'h00);
        chk("por.halted",   {31'd0, bus.halted},   32'h0);
        chk("por.dmem_we",  {31'd0, bus.dmem_we},  32'h0);
        chk("por.alu_ctrl", {28'd0, bus.alu_ctrl}, 32'hF);
        chk("por.rd_data",  {24'd0, bus.rd_data},  32'h00);
        $display("power-on reset: pc=%02h acc=%02h alu_ctrl=%h", bus.pc, bus.acc_out, bus.alu_ctrl);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Immediate sequence, cycle by cycle.
        load_and_reset(64'h1705_1003_3030_3030, 8'h30);
        chk("imm.c0_ctrl", {28'd0, bus.alu_ctrl}, 32'hF);
        repeat (2) @(negedge clk);
        chk("imm.op1_ctrl", {28'd0, bus.alu_ctrl}, 32'hF);
        chk("imm.op1_rd",   {24'd0, bus.rd_data},  32'h05);
        chk("imm.op1_acc",  {24'd0, bus.acc_out},  32'h00);
        @(negedge clk);
        chk("imm.c3_acc", {24'd0, bus.acc_out}, 32'h05);
        chk("imm.c3_rd",  {24'd0, bus.rd_data}, 32'h00);
        repeat (2) @(negedge clk);
        chk("imm.op2_ctrl", {28'd0, bus.alu_ctrl}, 32'h8);
        chk("imm.op2_rd",   {24'd0, bus.rd_data},  32'h03);
        @(negedge clk);
        chk("imm.c6_acc",  {24'd0, bus.acc_out},  32'h08);
        chk("imm.c6_ctrl", {28'd0, bus.alu_ctrl}, 32'hF);
        $display("seq imm: acc=%02h pc=%02h", bus.acc_out, bus.pc);

        // Store strobe shape, then register SUB.
        load_and_reset(64'h1708_0292_3030_3030, 8'h30);
        repeat (4) @(negedge clk);
        chk("st.we",    {31'd0, bus.dmem_we},    32'h1);
        chk("st.addr",  {28'd0, bus.dmem_addr},  32'h2);
        chk("st.wdata", {24'd0, bus.dmem_wdata}, 32'h08);
        @(negedge clk);
        chk("st.we_off", {31'd0, bus.dmem_we}, 32'h0);
        chk("st.mem2",   {24'd0, dmem[2]},     32'h08);
        repeat (2) @(negedge clk);
        chk("sub.exec_ctrl", {28'd0, bus.alu_ctrl}, 32'h9);
        chk("sub.exec_rd",   {24'd0, bus.rd_data},  32'h08);
        @(negedge clk);
        chk("sub.acc", {24'd0, bus.acc_out}, 32'h00);
        chk("sub.pc",  {24'd0, bus.pc},      32'h04);
        $display("seq st/sub: mem2=%02h acc=%02h writes=%0d", dmem[2], bus.acc_out, wr_cnt);

        // Asynchronous reset while the SUB is in its execute cycle.
        load_and_reset(64'h1705_9230_3030_3030, 8'h30);
        repeat (5) @(negedge clk);
        chk("rst.pre_ctrl", {28'd0, bus.alu_ctrl}, 32'h9);
        rst_n = 1'b0;
        #1;
        chk("rst.pc",       {24'd0, bus.pc},       32'h00);
        chk("rst.acc",      {24'd0, bus.acc_out},  32'h00);
        chk("rst.alu_ctrl", {28'd0, bus.alu_ctrl}, 32'hF);
        chk("rst.dmem_we",  {31'd0, bus.dmem_we},  32'h0);
        chk("rst.halted",   {31'd0, bus.halted},   32'h0);
        chk("rst.rd_data",  {24'd0, bus.rd_data},  32'h00);
        repeat (2) @(negedge clk);
        chk("rst.hold_acc", {24'd0, bus.acc_out}, 32'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.restart_pc",  {24'd0, bus.pc},      32'h02);
        chk("rst.restart_acc", {24'd0, bus.acc_out}, 32'h05);
        $display("seq reset mid-op: pc=%02h acc=%02h", bus.pc, bus.acc_out);

        // HALT holds everything until reset.
        load_and_reset(64'h3030_3030_3030_3030, 8'h30);
        repeat (2) @(negedge clk);
        chk("halt.halted", {31'd0, bus.halted}, 32'h1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("halt.pc", {24'd0, bus.pc},      32'h01);
            chk("halt.we", {31'd0, bus.dmem_we}, 32'h0);
        end
        chk("halt.still", {31'd0, bus.halted}, 32'h1);
        chk("halt.acc",   {24'd0, bus.acc_out}, 32'h00);
        chk("halt.writes", wr_cnt, 0);
        $display("seq halt: pc=%02h halted=%0b writes=%0d", bus.pc, bus.halted, wr_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
